// File: rtl/rs_ff_scheduler.sv
// rs_ff_scheduler: two-requester round-robin sequencer that pulses S/R lines of an RS flip-flop bank.
//   Clk              rising-edge clock
//   Reset_L          asynchronous active-low reset
//   Req0/Req1        requests, held until the matching Ack
//   Cmd0/Cmd1        1 = set, 0 = reset
//   Idx0/Idx1        target flip-flop index
//   Ack0/Ack1        one-cycle completion pulses
//   S/R              registered set/reset lines, never both high on any bit
//   Q                flip-flop bank feedback (read only with RS_SCHED_VERIFY_EN)
//   Busy             high while a transaction is in flight
//   Err              sticky: out-of-range index, or read-back mismatch with RS_SCHED_VERIFY_EN
// Define RS_SCHED_VERIFY_EN to add the CHECK state that compares Q[idx] with the command.
module rs_ff_scheduler #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic             Req0,
    input  logic             Req1,
    input  logic             Cmd0,
    input  logic             Cmd1,
    input  logic [IDX_W-1:0] Idx0,
    input  logic [IDX_W-1:0] Idx1,
    output logic             Ack0,
    output logic             Ack1,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Err
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
    state_t state;
    logic ptr, cur_sel, cur_cmd;
    logic [WIDTH-1:0] cur_mask;
    logic gnt_valid, gnt_sel, gnt_cmd;
    logic [IDX_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_mask;
    always_comb begin
        gnt_valid = Req0 | Req1;
        gnt_sel   = Req1 & (~Req0 | ptr);
        gnt_cmd   = gnt_sel ? Cmd1 : Cmd0;
        gnt_idx   = gnt_sel ? Idx1 : Idx0;
        // an index at or above WIDTH shifts the bit out, leaving an empty mask
        gnt_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << gnt_idx;
    end
`ifndef RS_SCHED_VERIFY_EN
    logic unused_ok;
    assign unused_ok = ^{Q, cur_cmd, cur_mask};
`endif
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            S        <= '0;
            R        <= '0;
            Ack0     <= 1'b0;
            Ack1     <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b0;
            ptr      <= 1'b0;
            cur_sel  <= 1'b0;
            cur_cmd  <= 1'b0;
            cur_mask <= '0;
        end else begin
            S    <= '0;
            R    <= '0;
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            case (state)
                IDLE: if (gnt_valid) begin
                    state    <= DRIVE;
                    Busy     <= 1'b1;
                    ptr      <= ~gnt_sel;
                    cur_sel  <= gnt_sel;
                    cur_cmd  <= gnt_cmd;
                    cur_mask <= gnt_mask;
                    S        <= gnt_cmd ? gnt_mask : '0;
                    R        <= gnt_cmd ? '0 : gnt_mask;
                    if (gnt_mask == '0) Err <= 1'b1;
                end
                DRIVE: begin
                    state <= SETTLE;
`ifndef RS_SCHED_VERIFY_EN
                    Ack0  <= ~cur_sel;
                    Ack1  <= cur_sel;
`endif
                end
`ifdef RS_SCHED_VERIFY_EN
                SETTLE: begin
                    state <= CHECK;
                    Ack0  <= ~cur_sel;
                    Ack1  <= cur_sel;
                    // Q has had the SETTLE cycle to follow the pulse; sample it here
                    if (cur_mask != '0 && (|(Q & cur_mask)) != cur_cmd) Err <= 1'b1;
                end
                CHECK: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
`else
                SETTLE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs_ff_scheduler.sv
// tb_rs_ff_scheduler: randomized check of rs_ff_scheduler against a transaction-level queue model.
module tb_rs_ff_scheduler;
    localparam int W = 6;
    localparam int IDX_W = 3;
`ifdef RS_SCHED_VERIFY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic a0;
        logic a1;
        logic busy;
        logic err_set;
    } rec_t;
    logic Clk;
    logic Reset_L = 1'b1;
    logic Req0 = 0, Req1 = 0, Cmd0 = 0, Cmd1 = 0;
    logic [IDX_W-1:0] Idx0 = '0, Idx1 = '0;
    logic Ack0, Ack1, Busy, Err;
    logic [W-1:0] S, R, Q;
    logic [W-1:0] bank = '0;
    logic [W-1:0] stuck0 = '0;
    rec_t exp_q[$];
    rec_t idle_rec = '{s: '0, r: '0, a0: 1'b0, a1: 1'b0, busy: 1'b0, err_set: 1'b0};
    logic ptr_m = 1'b0;
    logic err_m = 1'b0;
    logic hold = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    rs_ff_scheduler #(.WIDTH(W), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Reset_L(Reset_L),
        .Req0(Req0), .Req1(Req1), .Cmd0(Cmd0), .Cmd1(Cmd1),
        .Idx0(Idx0), .Idx1(Idx1), .Ack0(Ack0), .Ack1(Ack1),
        .S(S), .R(R), .Q(Q), .Busy(Busy), .Err(Err)
    );
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end
    // flip-flop bank: set dominates nothing since S & R never overlap; stuck0 bits read back as 0
    always_ff @(posedge Clk) bank <= (bank | S) & ~R;
    assign Q = bank & ~stuck0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    task automatic model_step();
        logic w, cmd;
        logic [IDX_W-1:0] idx;
        logic [W-1:0] hot;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].err_set) err_m = 1'b1;
        if (exp_q.size() == 0 && (Req0 || Req1)) begin
            w = (Req0 && Req1) ? ptr_m : Req1;
            ptr_m = !w;
            cmd = w ? Cmd1 : Cmd0;
            idx = w ? Idx1 : Idx0;
            hot = '0;
            if (int'(idx) < W) hot[idx] = 1'b1;
            else err_m = 1'b1;
            exp_q.push_back('{s: cmd ? hot : '0, r: cmd ? '0 : hot, a0: 1'b0, a1: 1'b0, busy: 1'b1, err_set: 1'b0});
`ifdef RS_SCHED_VERIFY_EN
            exp_q.push_back('{s: '0, r: '0, a0: 1'b0, a1: 1'b0, busy: 1'b1, err_set: 1'b0});
            exp_q.push_back('{s: '0, r: '0, a0: !w, a1: w, busy: 1'b1, err_set: cmd && ((hot & stuck0) != '0)});
`else
            exp_q.push_back('{s: '0, r: '0, a0: !w, a1: w, busy: 1'b1, err_set: 1'b0});
`endif
            exp_q.push_back(idle_rec);
        end
    endtask
    task automatic cycle();
        rec_t cur;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        cur = (exp_q.size() > 0) ? exp_q[0] : idle_rec;
        check("S", 32'(S), 32'(cur.s));
        check("R", 32'(R), 32'(cur.r));
        check("S_and_R", 32'(S & R), 32'd0);
        check("Ack0", 32'(Ack0), 32'(cur.a0));
        check("Ack1", 32'(Ack1), 32'(cur.a1));
        check("Busy", 32'(Busy), 32'(cur.busy));
        check("Err", 32'(Err), 32'(err_m));
        if (!hold && cur.a0) Req0 = 1'b0;
        if (!hold && cur.a1) Req1 = 1'b0;
    endtask
    task automatic do_reset();
        Reset_L = 1'b0;
        #1;
        check("rst_S", 32'(S), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_Ack", 32'({Ack1, Ack0}), 32'd0);
        check("rst_Busy", 32'(Busy), 32'd0);
        check("rst_Err", 32'(Err), 32'd0);
        exp_q.delete();
        ptr_m = 1'b0;
        err_m = 1'b0;
        @(negedge Clk);
        Reset_L = 1'b1;
    endtask
    initial begin
        #2;
        do_reset();
        Req0 = 1; Cmd0 = 1; Idx0 = 3'd5;
        repeat (LAT + 2) cycle();
        do_reset();
        Req0 = 1; Cmd0 = 1; Idx0 = 3'd2;
        Req1 = 1; Cmd1 = 0; Idx1 = 3'd2;
        repeat (2 * (LAT + 1) + 1) cycle();
        hold = 1'b1;
        Req0 = 1; Req1 = 1;
        repeat (6 * (LAT + 1)) cycle();
        hold = 1'b0;
        Req0 = 0; Req1 = 0;
        repeat (LAT + 1) cycle();
        Req1 = 1; Cmd1 = 1; Idx1 = 3'd7;
        repeat (LAT + 2) cycle();
        Req0 = 1; Cmd0 = 0; Idx0 = 3'd1;
        repeat (LAT + 2) cycle();
        do_reset();
        Req0 = 1; Cmd0 = 1; Idx0 = 3'd3;
        cycle();
        do_reset();
        Req1 = 1; Cmd1 = 0; Idx1 = 3'd0;
        repeat (2 * (LAT + 1) + 1) cycle();
`ifdef RS_SCHED_VERIFY_EN
        stuck0 = 6'b010000;
        Req0 = 1; Cmd0 = 1; Idx0 = 3'd4;
        repeat (LAT + 2) cycle();
        do_reset();
        stuck0 = '0;
`endif
        for (int i = 0; i < 800; i++) begin
            if (!Req0 && $urandom_range(0, 2) == 0) begin
                Req0 = 1'b1;
                Cmd0 = 1'($urandom_range(0, 1));
                Idx0 = IDX_W'($urandom_range(0, 7));
            end
            if (!Req1 && $urandom_range(0, 2) == 0) begin
                Req1 = 1'b1;
                Cmd1 = 1'($urandom_range(0, 1));
                Idx1 = IDX_W'($urandom_range(0, 7));
            end
            if (Req0 && $urandom_range(0, 29) == 0) Req0 = 1'b0;
            if (Req1 && $urandom_range(0, 29) == 0) Req1 = 1'b0;
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs_ff_scheduler.md
RS_FF_SCHEDULER -- requirements
Module: rs_ff_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: number of RS flip-flops in the controlled bank.
REQ-002 Parameter IDX_W, default 3: width of the bit-index fields.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset_L  input  1  asynchronous, active-low reset.
REQ-005 Req0 / Req1  input  1  request from requester 0 / 1; held high until the matching Ack.
REQ-006 Cmd0 / Cmd1  input  1  operation: 1 = set, 0 = reset.
REQ-007 Idx0 / Idx1  input  IDX_W  target flip-flop index.
REQ-008 Ack0 / Ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 S  output  WIDTH  registered set lines to the flip-flop bank.
REQ-010 R  output  WIDTH  registered reset lines to the flip-flop bank.
REQ-011 Q  input  WIDTH  Q feedback from the flip-flop bank.
REQ-012 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 Err  output  1  sticky error flag.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SETTLE and CHECK; Busy is high in DRIVE, SETTLE and CHECK.
REQ-015 IDLE: on any Req high, the block SHALL grant one requester, latch its Cmd and Idx, and go to DRIVE at that edge.
REQ-016 Arbitration SHALL be round-robin with a 1-bit priority pointer: a lone requester always wins; when both request, the pointer's requester wins; after each grant the pointer moves to the other requester.
REQ-017 Requests SHALL only be sampled in IDLE; a request arriving during a transaction waits.
REQ-018 DRIVE: for exactly one cycle, S[idx] = 1 if Cmd = 1, else R[idx] = 1; every other S/R bit SHALL be 0.
REQ-019 R & S SHALL be all-zero on every cycle, so the forbidden R = S = 1 input is never produced on any bit.
REQ-020 SETTLE: all R/S SHALL be 0 for one cycle; next state is CHECK.
REQ-021 CHECK: the granted Ack SHALL pulse high for this one cycle; next state is IDLE.
REQ-022 Latency: grant edge N gives DRIVE in cycle N+1, SETTLE in N+2 and Ack in N+3; the earliest next grant is at edge N+4.
REQ-023 Index at or above WIDTH: R/S SHALL stay 0 in DRIVE, Err SHALL be set, and Ack still pulses at normal latency.
REQ-024 If Req drops before Ack, the latched transaction SHALL still complete and Ack SHALL still pulse.
REQ-025 Ack0 and Ack1 SHALL never be high in the same cycle.

Reset
REQ-026 When Reset_L is low, the block SHALL asynchronously force: state IDLE, S = 0, R = 0, Ack0 = Ack1 = 0, Busy = 0, Err = 0, pointer = requester 0.
REQ-027 Reset mid-transaction SHALL abort it with no Ack; the interrupted request is re-arbitrated after release if still held.
REQ-028 After Reset_L deasserts, the first grant SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-029 With RS_SCHED_VERIFY_EN defined, CHECK SHALL compare Q[idx] with the latched Cmd; a mismatch sets Err (sticky until reset), and Ack still pulses.
REQ-030 Without RS_SCHED_VERIFY_EN, the CHECK state SHALL be omitted:
- Ack pulses in the SETTLE cycle (latency N+2).
- Q is ignored.
- Err is set only by out-of-range indices.

Verification
REQ-031 Req0 = 1, Cmd0 = 1, Idx0 = 5 from IDLE -> S = 8'h20 for one cycle, then Ack0 pulse 3 cycles after the grant; Busy high for 3 cycles.
REQ-032 Req0 and Req1 rise together, pointer = 0, Idx0 = 2 set, Idx1 = 2 reset -> S = 8'h04 first, Ack0; then R = 8'h04, Ack1; R & S never nonzero together.
REQ-033 Both requesters held continuously for 6 transactions -> grant order 0, 1, 0, 1, 0, 1.
REQ-034 WIDTH = 6, Idx1 = 7 -> R = S = 0 throughout, Err = 1, Ack1 pulses; Err stays 1 until Reset_L is pulsed low.
REQ-035 Reset_L low during DRIVE of a set on Idx = 3 -> S goes to 0 immediately, no Ack, Busy = 0, pointer = 0.
REQ-036 With RS_SCHED_VERIFY_EN, bank model holds Q[4] = 0 while a set is issued on Idx = 4 -> Err = 1 in CHECK and Ack0 still pulses.
